// File: rtl/range_arb_pkg.sv
// Shared types and helpers for the range session arbiter.
// Holds the controller state enum, count width and round-robin pick.
package range_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CALC,
    RESULT
  } state_e;

  localparam int COUNT_W = 16;
  localparam int MAX_REQ = 8;

  // First set bit at or above ptr; falls back to the lowest set bit
  // so the search wraps around.
  function automatic logic [2:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr
  );
    logic [MAX_REQ-1:0] masked;
    logic [2:0]         idx;
    masked = req & ~((8'd1 << ptr) - 8'd1);
    idx    = '0;
    if (masked != '0) begin
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
        if (masked[i]) idx = 3'(i);
      end
    end else begin
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
        if (req[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/range_tracker.sv
// Registered running min/max of a sample stream.
// Ports: clock, reset, clear (min<-ones, max<-0), en + data update, min_q/max_q.
module range_tracker #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] min_q,
  output logic [WIDTH-1:0] max_q
);

  logic [WIDTH-1:0] min_d;
  logic [WIDTH-1:0] max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
    end else if (en) begin
      if (data < min_q) min_d = data;
      if (data > max_q) max_d = data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/range_session_arbiter.sv
// Round-robin owner of one min/max tracker for whole sample sessions.
// Ports: per-requester valid/data/last/ready, grant, busy, result handshake.
module range_session_arbiter
  import range_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic [WIDTH-1:0]           result_range,
  output logic [COUNT_W-1:0]         result_count,
  output logic                       result_error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0]   res_range_q, res_range_d;
  logic [COUNT_W-1:0] res_count_q, res_count_d;
  logic               res_error_q, res_error_d;

  logic               trk_clear;
  logic               trk_en;
  logic [WIDTH-1:0]   min_q;
  logic [WIDTH-1:0]   max_q;

  logic [MAX_REQ-1:0] vld_ext;
  logic [2:0]         ptr_ext;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   own_data;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic [TW-1:0]      timer_inc;

  always_comb begin
    vld_ext = '0;
    vld_ext[NUM_REQ-1:0] = req_valid;
  end

  assign ptr_ext   = 3'(rr_ptr_q);
  assign pick_idx  = IDX_W'(rr_pick(vld_ext, ptr_ext));
  assign own_data  = req_data[owner_q*WIDTH +: WIDTH];
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign xfer      = (state_q == STREAM) && own_valid;
  assign timer_inc = timer_q + TW'(1);

  assign req_ready    = (state_q == STREAM) ? grant_q : '0;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == RESULT);
  assign result_id    = res_id_q;
  assign result_range = res_range_q;
  assign result_count = res_count_q;
  assign result_error = res_error_q;

  range_tracker #(
    .WIDTH (WIDTH)
  ) u_tracker (
    .clock (clock),
    .reset (reset),
    .clear (trk_clear),
    .en    (trk_en),
    .data  (own_data),
    .min_q (min_q),
    .max_q (max_q)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    timer_d     = timer_q;
    res_id_d    = res_id_q;
    res_range_d = res_range_q;
    res_count_d = res_count_q;
    res_error_d = res_error_q;
    trk_clear   = 1'b0;
    trk_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d   = pick_idx;
          grant_d   = NUM_REQ'(1) << pick_idx;
          trk_clear = 1'b1;
          count_d   = '0;
          timer_d   = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          trk_en  = 1'b1;
          timer_d = '0;
          if (count_q != '1) count_d = count_q + COUNT_W'(1);
          if (own_last) state_d = CALC;
        end else begin
          timer_d = timer_inc;
          // Abort: report the partial count with a zero range.
          if (timer_inc == TW'(TIMEOUT)) begin
            res_id_d    = owner_q;
            res_range_d = '0;
            res_count_d = count_q;
            res_error_d = 1'b1;
            state_d     = RESULT;
          end
        end
      end
      CALC: begin
        // At least one beat was seen, so max >= min and no wrap.
        res_id_d    = owner_q;
        res_range_d = max_q - min_q;
        res_count_d = count_q;
        res_error_d = 1'b0;
        state_d     = RESULT;
      end
      RESULT: begin
        if (result_ready) begin
          grant_d  = '0;
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ?
                     '0 : owner_q + IDX_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      res_id_q    <= '0;
      res_range_q <= '0;
      res_count_q <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      res_id_q    <= res_id_d;
      res_range_q <= res_range_d;
      res_count_q <= res_count_d;
      res_error_q <= res_error_d;
    end
  end

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter (WIDTH=16, NUM_REQ=4, TIMEOUT=64).
// Table of sessions plus hand sequences for hold, timeout, reset, round-robin.
module tb_range_session_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_id;
  logic [15:0] result_range;
  logic [15:0] result_count;
  logic        result_error;

  int total = 0;
  int bad   = 0;

  range_session_arbiter #(
    .WIDTH   (16),
    .NUM_REQ (4),
    .TIMEOUT (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .result_range (result_range),
    .result_count (result_count),
    .result_error (result_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    int          nb;
    logic [15:0] d [4];
    logic [15:0] rng;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {grant, req_ready, busy, result_valid, result_id,
             result_range, result_count, result_error}, 64'd0);
  endtask

  task automatic run_session(input vec_t v);
    req_data  = '0;
    req_last  = '0;
    req_valid = 4'(1) << v.id;
    req_data[v.id*16 +: 16] = v.d[0];
    tick();
    chk("grant", grant, 4'(1) << v.id);
    chk("req_ready", req_ready, 4'(1) << v.id);
    for (int b = 0; b < v.nb; b++) begin
      req_data[v.id*16 +: 16] = v.d[b];
      req_last = (b == v.nb - 1) ? 4'(1) << v.id : 4'd0;
      tick();
    end
    req_valid = '0;
    req_last  = '0;
    chk("calc_no_valid", result_valid, 0);
    tick();
    chk("result_valid", result_valid, 1);
    chk("result_id", result_id, v.id);
    chk("result_range", result_range, v.rng);
    chk("result_count", result_count, v.cnt);
    chk("result_error", result_error, 0);
    result_ready = 1'b1;
    tick();
    chk("accepted", {result_valid, busy, grant}, 0);
    result_ready = 1'b0;
  endtask

  initial begin
    logic        seen;
    logic [15:0] held_range;
    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    result_ready = 1'b0;

    vt[0] = '{1, 3, '{16'd7, 16'd3, 16'd12, 16'd0}, 16'd9, 16'd3};
    vt[1] = '{0, 1, '{16'h5A5A, 16'd0, 16'd0, 16'd0}, 16'd0, 16'd1};
    vt[2] = '{3, 2, '{16'h0000, 16'hFFFF, 16'd0, 16'd0}, 16'hFFFF, 16'd2};
    vt[3] = '{2, 3, '{16'd5, 16'd5, 16'd5, 16'd0}, 16'd0, 16'd3};
    vt[4] = '{0, 4, '{16'd100, 16'd20, 16'd300, 16'd50}, 16'd280, 16'd4};

    repeat (2) tick();
    chk_reset_outs("reset_outs");
    reset = 1'b0;
    tick();
    chk_reset_outs("idle_after_reset");

    for (int i = 0; i < 5; i++) run_session(vt[i]);

    // Owner 0 session while requester 1 asserts valid+last: ignored.
    req_data  = '0;
    req_valid = 4'b0001;
    req_data[15:0] = 16'h1234;
    tick();
    chk("hold_grant", grant, 4'b0001);
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    req_data[31:16] = 16'h0FFF;
    tick();
    chk("other_last_ignored", {result_valid, busy, req_ready}, 6'b0_1_0001);
    req_data[15:0] = 16'h1000;
    req_last  = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    chk("hold_first", {result_id, result_range, result_count,
                       result_error}, {2'd0, 16'h0234, 16'd2, 1'b0});
    held_range = result_range;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_stable", {result_valid, grant, result_id, result_range,
                          result_count, result_error},
          {1'b1, 4'b0001, 2'd0, held_range, 16'd2, 1'b0});
    end
    result_ready = 1'b1;
    tick();
    chk("hold_accept", {result_valid, busy, grant}, 0);
    result_ready = 1'b0;
    tick();
    chk("next_grant_rr", grant, 4'b0010);
    tick();
    req_valid = '0;
    req_last  = '0;
    tick();
    chk("req1_result", {result_valid, result_id, result_range,
                        result_count}, {1'b1, 2'd1, 16'd0, 16'd1});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Timeout: one beat from requester 2, then silence.
    req_data  = '0;
    req_valid = 4'b0100;
    req_data[47:32] = 16'h0040;
    tick();
    chk("to_grant", grant, 4'b0100);
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      seen = seen | result_valid;
    end
    chk("to_not_early", seen, 0);
    tick();
    chk("to_result", {result_valid, result_id, result_range,
                      result_count, result_error},
        {1'b1, 2'd2, 16'd0, 16'd1, 1'b1});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("to_accept", {result_valid, busy}, 0);
    run_session('{2, 2, '{16'd9, 16'd4, 16'd0, 16'd0}, 16'd5, 16'd2});

    // Reset mid-STREAM discards the session.
    req_data  = '0;
    req_valid = 4'b1000;
    req_data[63:48] = 16'h0777;
    tick();
    tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outs("async_reset");
    req_valid = '0;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      seen = seen | result_valid | busy;
    end
    chk("no_result_after_reset", seen, 0);

    // Round-robin with everyone requesting; rr_ptr is 0 after reset.
    req_valid    = 4'b1111;
    req_last     = 4'b1111;
    req_data     = 64'h0033_0022_0011_0000;
    result_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 20 && !result_valid; k++) tick();
      chk("rr_valid", result_valid, 1);
      chk("rr_order", {result_id, result_range, result_count},
          {2'(s % 4), 16'd0, 16'd1});
      tick();
    end
    req_valid    = '0;
    req_last     = '0;
    result_ready = 1'b0;
    tick();
    chk("rr_idle", {busy, grant}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
